ahb_dma_master: RTL and testbench



---
 rtl/ahb_dma_master.sv | 247 ++++++++++++++++++++++++
 tb/tb_ahb_dma_master.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_dma_master.sv
// AHB DMA master: copies words src->dst in chunks (read burst into a buffer, then write burst).
// Optional macro AHB_DMA_LOCK_EN holds HLOCK across each read+write chunk.
module ahb_dma_master #(
   parameter int BURST_LEN = 4,
   parameter int LEN_BITS  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [31:0]         src_addr,
   input  logic [31:0]         dst_addr,
   input  logic [LEN_BITS-1:0] len,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic                HBUSREQ,
   output logic                HLOCK,
   input  logic                HGRANT,
   output logic [1:0]          HTRANS,
   output logic [31:0]         HADDR,
   output logic                HWRITE,
   output logic [2:0]          HSIZE,
   output logic [2:0]          HBURST,
   output logic [3:0]          HPROT,
   output logic [31:0]         HWDATA,
   input  logic [31:0]         HRDATA,
   input  logic                HREADY,
   input  logic [1:0]          HRESP
);

   localparam int CW = $clog2(BURST_LEN + 1);
   localparam int IW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   localparam logic [CW-1:0] ONE       = CW'(1);
   localparam logic [31:0]   ADDR_MASK = 32'hFFFF_FFFC;

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_NONSEQ = 2'b10;
   localparam logic [1:0] T_SEQ    = 2'b11;

   localparam logic [1:0] R_OKAY  = 2'b00;
   localparam logic [1:0] R_ERROR = 2'b01;

`ifdef AHB_DMA_LOCK_EN
   localparam logic LOCK_EN = 1'b1;
`else
   localparam logic LOCK_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_RD,
      S_WR,
      S_FIN
   } state_t;

   state_t              state;
   logic [31:0]         src_base;
   logic [31:0]         dst_base;
   logic [LEN_BITS-1:0] remaining;
   logic [CW-1:0]       chunk;
   logic [CW-1:0]       a_idx;
   logic [CW-1:0]       bus_idx;
   logic [CW-1:0]       dp_idx;
   logic                dp_valid;
   logic                have_data;
   logic [31:0]         buf_mem [BURST_LEN];

   logic [31:0]         beat_addr;
   logic [LEN_BITS-1:0] rem_nxt;
   logic [31:0]         src_nxt;
   logic [31:0]         dst_nxt;
   logic                last_dp;

   // Chunk never crosses a 1KB boundary on either side, so one burst stays legal.
   function automatic logic [CW-1:0] chunk_size(
      input logic [LEN_BITS-1:0] rem,
      input logic [31:0]         s,
      input logic [31:0]         d
   );
      logic [31:0] m;
      logic [31:0] bs;
      logic [31:0] bd;
      m  = BURST_LEN;
      bs = 32'd256 - 32'(s[9:2]);
      bd = 32'd256 - 32'(d[9:2]);
      if (32'(rem) < m) m = 32'(rem);
      if (bs < m) m = bs;
      if (bd < m) m = bd;
      return m[CW-1:0];
   endfunction

   assign beat_addr = (have_data ? dst_base : src_base) + (32'(a_idx) << 2);
   assign rem_nxt   = remaining - LEN_BITS'(chunk);
   assign src_nxt   = src_base + (32'(chunk) << 2);
   assign dst_nxt   = dst_base + (32'(chunk) << 2);
   assign last_dp   = dp_valid && (dp_idx == chunk - ONE);

   assign HSIZE  = 3'b010;
   assign HBURST = 3'b001;
   assign HPROT  = 4'b0011;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         HBUSREQ   <= 1'b0;
         HLOCK     <= 1'b0;
         HTRANS    <= T_IDLE;
         HADDR     <= '0;
         HWRITE    <= 1'b0;
         HWDATA    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         src_base  <= '0;
         dst_base  <= '0;
         remaining <= '0;
         chunk     <= '0;
         a_idx     <= '0;
         bus_idx   <= '0;
         dp_idx    <= '0;
         dp_valid  <= 1'b0;
         have_data <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  err <= 1'b0;
                  if (len == '0) begin
                     done <= 1'b1;
                  end else begin
                     src_base  <= src_addr & ADDR_MASK;
                     dst_base  <= dst_addr & ADDR_MASK;
                     remaining <= len;
                     chunk     <= chunk_size(len, src_addr & ADDR_MASK,
                                             dst_addr & ADDR_MASK);
                     a_idx     <= '0;
                     have_data <= 1'b0;
                     dp_valid  <= 1'b0;
                     busy      <= 1'b1;
                     HBUSREQ   <= 1'b1;
                     HLOCK     <= LOCK_EN;
                     state     <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (HGRANT && HREADY) begin
                  HTRANS  <= T_NONSEQ;
                  HADDR   <= beat_addr;
                  HWRITE  <= have_data;
                  bus_idx <= a_idx;
                  a_idx   <= a_idx + ONE;
                  state   <= have_data ? S_WR : S_RD;
               end
            end
            S_RD, S_WR: begin
               if (dp_valid && HRESP != R_OKAY) begin
                  // Two-cycle response: cancel the pipelined beat in the first cycle.
                  HTRANS <= T_IDLE;
                  if (HREADY) begin
                     dp_valid <= 1'b0;
                     if (HRESP == R_ERROR) begin
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        HBUSREQ   <= 1'b0;
                        HLOCK     <= 1'b0;
                        have_data <= 1'b0;
                        state     <= S_FIN;
                     end else begin
                        a_idx <= dp_idx;
                        state <= S_REQ;
                     end
                  end
               end else if (HREADY) begin
                  if (dp_valid && state == S_RD)
                     buf_mem[IW'(dp_idx)] <= HRDATA;
                  if (HTRANS != T_IDLE) begin
                     dp_valid <= 1'b1;
                     dp_idx   <= bus_idx;
                     if (HWRITE)
                        HWDATA <= buf_mem[IW'(bus_idx)];
                     if (HWRITE && bus_idx == chunk - ONE)
                        HLOCK <= 1'b0;
                  end else begin
                     dp_valid <= 1'b0;
                  end
                  if (HTRANS != T_IDLE && HGRANT && a_idx < chunk) begin
                     HTRANS  <= T_SEQ;
                     HADDR   <= HADDR + 32'd4;
                     bus_idx <= a_idx;
                     a_idx   <= a_idx + ONE;
                  end else begin
                     HTRANS <= T_IDLE;
                  end
                  if (last_dp) begin
                     if (state == S_RD) begin
                        have_data <= 1'b1;
                        if (HGRANT) begin
                           HTRANS  <= T_NONSEQ;
                           HADDR   <= dst_base;
                           HWRITE  <= 1'b1;
                           bus_idx <= '0;
                           a_idx   <= ONE;
                           state   <= S_WR;
                        end else begin
                           a_idx <= '0;
                           state <= S_REQ;
                        end
                     end else begin
                        have_data <= 1'b0;
                        a_idx     <= '0;
                        remaining <= rem_nxt;
                        src_base  <= src_nxt;
                        dst_base  <= dst_nxt;
                        chunk     <= chunk_size(rem_nxt, src_nxt, dst_nxt);
                        if (rem_nxt != '0) begin
                           HLOCK <= LOCK_EN;
                           state <= S_REQ;
                        end else begin
                           busy    <= 1'b0;
                           done    <= 1'b1;
                           HBUSREQ <= 1'b0;
                           HLOCK   <= 1'b0;
                           state   <= S_FIN;
                        end
                     end
                  end else if (HTRANS == T_IDLE) begin
                     // Grant was lost: the last data phase just drained.
                     state <= S_REQ;
                  end
               end
            end
            S_FIN: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_dma_master.sv
// Bench for ahb_dma_master: slave/arbiter model with a beat scoreboard and a done monitor.
`timescale 1ns/1ps
module tb_ahb_dma_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] src_addr = '0;
   logic [31:0] dst_addr = '0;
   logic [15:0] len = '0;
   logic        busy, done, err;
   logic        HBUSREQ, HLOCK, HWRITE;
   logic        HGRANT = 1'b1;
   logic [1:0]  HTRANS;
   logic [31:0] HADDR, HWDATA;
   logic [2:0]  HSIZE, HBURST;
   logic [3:0]  HPROT;
   logic [31:0] HRDATA = '0;
   logic        HREADY = 1'b1;
   logic [1:0]  HRESP = 2'b00;

   ahb_dma_master #(.BURST_LEN(4), .LEN_BITS(16)) dut (
      .clk(clk), .rst(rst), .start(start),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
      .busy(busy), .done(done), .err(err),
      .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HGRANT(HGRANT),
      .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
      .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        w;
      logic        ns;
      logic [31:0] addr;
      logic [31:0] data;
   } beat_t;

   beat_t       exp_q[$];
   logic        done_q[$];
   logic [31:0] wmem [logic [31:0]];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_done = 0;

   logic        pend = 1'b0;
   logic        pend_w = 1'b0;
   logic        pend_ns = 1'b0;
   logic [31:0] pend_addr = '0;
   int          pend_ridx = 0;
   int          rd_acc = 0;
   int          wr_acc = 0;
   int          err_beat = -1;
   int          drop_at = -1;
   int          regrant = 0;
   int          cyc = 0;
   logic        err_ph = 1'b0;
   logic        wait_en = 1'b0;
   logic        sb_off = 1'b0;

   function automatic logic [31:0] pat(input logic [31:0] a);
      return (a * 32'h0001_0003) ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", nm, act, want);
      end
   endtask

   task automatic exp_beat(input logic w, input logic ns,
                           input logic [31:0] a, input logic [31:0] d);
      beat_t b;
      b.w = w; b.ns = ns; b.addr = a; b.data = d;
      exp_q.push_back(b);
   endtask

   // Expected beats for one chunk: reads from s, then writes to d.
   task automatic exp_chunk(input logic [31:0] s, input logic [31:0] d,
                            input int n);
      for (int i = 0; i < n; i++)
         exp_beat(1'b0, i == 0, s + 32'(4 * i), 32'h0);
      for (int i = 0; i < n; i++)
         exp_beat(1'b1, i == 0, d + 32'(4 * i), pat(s + 32'(4 * i)));
   endtask

   // Slave, arbiter and beat scoreboard, evaluated mid-cycle.
   always @(negedge clk) begin : bus
      logic       rdy;
      logic [1:0] resp;
      beat_t      e;
      if (rst) begin
         pend = 1'b0; err_ph = 1'b0; regrant = 0;
         HREADY = 1'b1; HRESP = 2'b00; HRDATA = '0; HGRANT = 1'b1;
      end else begin
         cyc++;
         rdy = 1'b1;
         resp = 2'b00;
         if (regrant > 0) begin
            regrant--;
            if (regrant == 0) HGRANT = 1'b1;
         end
         if (err_ph) begin
            resp = 2'b01;
            err_ph = 1'b0;
            chk("idle_in_2nd_err_cycle", 32'(HTRANS), 32'(2'b00));
         end else if (pend && !pend_w && pend_ridx == err_beat) begin
            rdy = 1'b0;
            resp = 2'b01;
            err_ph = 1'b1;
         end else if (pend && wait_en && (cyc % 3 == 0)) begin
            rdy = 1'b0;
         end
         if (drop_at >= 0 && HTRANS[1] && HWRITE && wr_acc == drop_at) begin
            HGRANT = 1'b0;
            regrant = 5;
            drop_at = -1;
         end
         HREADY = rdy;
         HRESP = resp;
         HRDATA = (pend && !pend_w) ? pat(pend_addr) : 32'h0;
         if (pend && rdy) begin
            if (pend_w) wmem[pend_addr] = HWDATA;
            if (!sb_off) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_beat: got addr %h write %0d, want none",
                           pend_addr, pend_w);
               end else begin
                  e = exp_q.pop_front();
                  chk("beat_addr", pend_addr, e.addr);
                  chk("beat_write", 32'(pend_w), 32'(e.w));
                  chk("beat_nonseq", 32'(pend_ns), 32'(e.ns));
                  if (e.w) chk("beat_wdata", HWDATA, e.data);
               end
            end
         end
         if (rdy) begin
            pend = HTRANS[1];
            if (HTRANS[1]) begin
               pend_addr = HADDR;
               pend_w = HWRITE;
               pend_ns = (HTRANS == 2'b10);
               if (HWRITE) begin
                  wr_acc++;
               end else begin
                  pend_ridx = rd_acc;
                  rd_acc++;
               end
            end
         end
      end
   end

   always @(negedge clk) begin : dmon
      logic e;
      if (!rst && done) begin
         n_done++;
         if (done_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1, want 0");
         end else begin
            e = done_q.pop_front();
            chk("done_err", 32'(err), 32'(e));
            chk("done_busy", 32'(busy), 32'h0);
         end
      end
   end

   task automatic go(input logic [31:0] s, input logic [31:0] d,
                     input logic [15:0] n);
      @(negedge clk);
      src_addr = s; dst_addr = d; len = n; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int target);
      for (int i = 0; i < 400 && n_done < target; i++) @(negedge clk);
      n_cmp++;
      if (n_done < target) begin
         n_bad++;
         $display("FAIL %s_timeout: got %0d done pulses, want %0d", nm, n_done, target);
      end
      repeat (4) @(negedge clk);
      chk({nm, "_beats_left"}, 32'(exp_q.size()), 32'h0);
   endtask

   task automatic mem_check(input logic [31:0] s, input logic [31:0] d,
                            input int n);
      logic [31:0] got;
      for (int i = 0; i < n; i++) begin
         got = wmem.exists(d + 32'(4 * i)) ? wmem[d + 32'(4 * i)] : 32'hDEAD_DEAD;
         chk("mem_image", got, pat(s + 32'(4 * i)));
      end
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_hbusreq"}, 32'(HBUSREQ), 32'h0);
      chk({nm, "_hlock"}, 32'(HLOCK), 32'h0);
      chk({nm, "_htrans"}, 32'(HTRANS), 32'h0);
      chk({nm, "_haddr"}, HADDR, 32'h0);
      chk({nm, "_hwrite"}, 32'(HWRITE), 32'h0);
      chk({nm, "_hwdata"}, HWDATA, 32'h0);
      chk({nm, "_busy"}, 32'(busy), 32'h0);
      chk({nm, "_done"}, 32'(done), 32'h0);
      chk({nm, "_err"}, 32'(err), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      chk("hsize", 32'(HSIZE), 32'h2);
      chk("hburst", 32'(HBURST), 32'h1);
      chk("hprot", 32'(HPROT), 32'h3);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 1: basic 4-word copy, plus a start pulse while busy
      exp_chunk(32'h1000, 32'h2000, 4);
      done_q.push_back(1'b0);
      go(32'h1000, 32'h2000, 16'd4);
      repeat (2) @(negedge clk);
      src_addr = 32'hF000; dst_addr = 32'hE000; len = 16'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("t1", 1);
      mem_check(32'h1000, 32'h2000, 4);

      // 2: two chunks (4 then 2) with slave wait states
      wait_en = 1'b1;
      exp_chunk(32'h3000, 32'h4000, 4);
      exp_chunk(32'h3010, 32'h4010, 2);
      done_q.push_back(1'b0);
      go(32'h3000, 32'h4000, 16'd6);
      wait_done("t2", 2);
      mem_check(32'h3000, 32'h4000, 6);
      wait_en = 1'b0;

      // 3: source crosses a 1KB boundary
      exp_chunk(32'h13F8, 32'h5000, 2);
      exp_chunk(32'h1400, 32'h5008, 2);
      done_q.push_back(1'b0);
      go(32'h13F8, 32'h5000, 16'd4);
      wait_done("t3", 3);
      mem_check(32'h13F8, 32'h5000, 4);

      // 4: ERROR on the third read beat
      err_beat = rd_acc + 2;
      exp_beat(1'b0, 1'b1, 32'h6000, 32'h0);
      exp_beat(1'b0, 1'b0, 32'h6004, 32'h0);
      exp_beat(1'b0, 1'b0, 32'h6008, 32'h0);
      done_q.push_back(1'b1);
      go(32'h6000, 32'h7000, 16'd4);
      wait_done("t4", 4);
      chk("t4_err_sticky", 32'(err), 32'h1);
      chk("t4_no_writes", 32'(wmem.exists(32'h7000)), 32'h0);
      err_beat = -1;

      // 5: grant removed while the second write beat is on the bus
      drop_at = wr_acc + 1;
      exp_beat(1'b0, 1'b1, 32'h8000, 32'h0);
      exp_beat(1'b0, 1'b0, 32'h8004, 32'h0);
      exp_beat(1'b0, 1'b0, 32'h8008, 32'h0);
      exp_beat(1'b0, 1'b0, 32'h800C, 32'h0);
      exp_beat(1'b1, 1'b1, 32'h9000, pat(32'h8000));
      exp_beat(1'b1, 1'b0, 32'h9004, pat(32'h8004));
      exp_beat(1'b1, 1'b1, 32'h9008, pat(32'h8008));
      exp_beat(1'b1, 1'b0, 32'h900C, pat(32'h800C));
      done_q.push_back(1'b0);
      go(32'h8000, 32'h9000, 16'd4);
      wait_done("t5", 5);
      mem_check(32'h8000, 32'h9000, 4);

      // 6: zero-length request
      done_q.push_back(1'b0);
      go(32'hC000, 32'hD000, 16'd0);
      chk("t6_done_next_cycle", 32'(done), 32'h1);
      for (int i = 0; i < 5; i++) begin
         chk("t6_hbusreq_low", 32'(HBUSREQ), 32'h0);
         @(negedge clk);
      end
      chk("t6_done_count", 32'(n_done), 32'd6);

      // 7: reset in the middle of a read burst
      sb_off = 1'b1;
      go(32'hA000, 32'hB000, 16'd8);
      begin
         int k;
         k = 0;
         while (HTRANS != 2'b11 && k < 50) begin
            @(negedge clk);
            k++;
         end
         chk("t7_reached_seq", 32'(HTRANS), 32'(2'b11));
      end
      rst = 1'b1;
      @(negedge clk);
      chk_reset_outputs("t7_midreset");
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t7_idle_after_reset", {30'h0, HTRANS} | 32'(HBUSREQ), 32'h0);
      end
      sb_off = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
